multicycle_ctrl: RTL and testbench



---
 rtl/riscv_pkg.sv | 44 ++++
 rtl/inst_class.sv | 38 +++
 rtl/multicycle_ctrl.sv | 142 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode classes, controller states, instruction classes.
package riscv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPC_W    = 5;
  localparam int unsigned OPCODE_W = 7;

  // Opcode class field inst[6:2]
  localparam logic [OPC_W-1:0] OPC_OP     = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_STORE  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 5'b11000;
  localparam logic [OPC_W-1:0] OPC_JAL    = 5'b11011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 5'b11001;
  localparam logic [OPC_W-1:0] OPC_LUI    = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 5'b00101;

  // inst[1:0] marker for 32-bit encodings
  localparam logic [1:0] INST_LEN32 = 2'b11;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } ctrl_state_e;

  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_OP     = 4'd1,
    CLS_OP_IMM = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9
  } inst_class_e;

endpackage

// File: rtl/inst_class.sv
// Combinational opcode classifier: maps the low opcode bits of an instruction to {class, legal}.
module inst_class
  import riscv_pkg::*;
(
  input  logic [OPCODE_W-1:0] i_opcode,
  output inst_class_e         o_class_c,
  output logic                o_legal_c
);

  logic [OPC_W-1:0] w_opc;
  logic             w_len32;

  assign w_opc   = i_opcode[OPCODE_W-1:2];
  assign w_len32 = (i_opcode[1:0] == INST_LEN32);

  // Class lookup; anything that is not a 32-bit encoding of a known class is illegal
  always_comb begin
    o_class_c = CLS_NONE;
    o_legal_c = 1'b0;
    case (w_opc)
      OPC_OP:     o_class_c = CLS_OP;
      OPC_OP_IMM: o_class_c = CLS_OP_IMM;
      OPC_LOAD:   o_class_c = CLS_LOAD;
      OPC_STORE:  o_class_c = CLS_STORE;
      OPC_BRANCH: o_class_c = CLS_BRANCH;
      OPC_JAL:    o_class_c = CLS_JAL;
      OPC_JALR:   o_class_c = CLS_JALR;
      OPC_LUI:    o_class_c = CLS_LUI;
      OPC_AUIPC:  o_class_c = CLS_AUIPC;
      default:    o_class_c = CLS_NONE;
    endcase
    if (!w_len32) begin
      o_class_c = CLS_NONE;
    end
    o_legal_c = (o_class_c != CLS_NONE);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: owns PC and IR, handshakes with imem/dmem, issues rd write strobe.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic [XLEN-1:0] o_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_inst,
  input  logic [XLEN-1:0] i_pc_next,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  input  logic            i_dmem_ack,
  output logic            o_rd_we,
  output logic            o_illegal,
  output logic [2:0]      o_state
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  ctrl_state_e     r_state;
  ctrl_state_e     w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] w_inst_next;
  inst_class_e     w_cls;
  logic            w_legal;
  logic            r_imem_req;
  logic            r_dmem_req;
  logic            r_dmem_we;
  logic            r_rd_we;
  logic            r_illegal;

  // IR loads only on a fetch acknowledge; otherwise it holds for the whole instruction
  assign w_inst_next = ((r_state == ST_FETCH) && i_imem_ack) ? i_imem_rdata : r_inst;

  // Classify the IR's next value so the illegal strobe can be registered on entry to DECODE;
  // outside the fetch-ack edge this is the current IR
  inst_class u_inst_class (
    .i_opcode  (w_inst_next[OPCODE_W-1:0]),
    .o_class_c (w_cls),
    .o_legal_c (w_legal)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and PC update
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      ST_BOOT: begin
        w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (i_imem_ack) begin
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_legal) begin
          w_state_next = ST_EXEC;
        end else begin
          w_pc_next    = r_pc + PC_STEP;
          w_state_next = ST_FETCH;
        end
      end
      ST_EXEC: begin
        case (w_cls)
          CLS_LOAD, CLS_STORE: w_state_next = ST_MEM;
          CLS_BRANCH: begin
            w_pc_next    = i_pc_next;
            w_state_next = ST_FETCH;
          end
          default: w_state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (i_dmem_ack) begin
          if (w_cls == CLS_STORE) begin
            w_pc_next    = i_pc_next;
            w_state_next = ST_FETCH;
          end else begin
            w_state_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        w_pc_next    = i_pc_next;
        w_state_next = ST_FETCH;
      end
      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

  // PC, IR and Moore strobes, registered from the state being entered
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc       <= RESET_PC;
      r_inst     <= '0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_rd_we    <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_inst     <= w_inst_next;
      r_imem_req <= (w_state_next == ST_FETCH);
      r_dmem_req <= (w_state_next == ST_MEM);
      r_dmem_we  <= (w_state_next == ST_MEM) && (w_cls == CLS_STORE);
      r_rd_we    <= (w_state_next == ST_WB);
      r_illegal  <= (w_state_next == ST_DECODE) && !w_legal;
    end
  end

  assign o_pc        = r_pc;
  assign o_imem_addr = r_pc;
  assign o_inst      = r_inst;
  assign o_imem_req  = r_imem_req;
  assign o_dmem_req  = r_dmem_req;
  assign o_dmem_we   = r_dmem_we;
  assign o_rd_we     = r_rd_we;
  assign o_illegal   = r_illegal;
  assign o_state     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases plus randomized instruction stream
// against an instruction-level timeline model.
module tb_multicycle_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  // Strobe vector layout {imem_req, dmem_req, dmem_we, rd_we, illegal}
  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_IREQ = 5'b10000;
  localparam logic [4:0] S_DREQ = 5'b01000;
  localparam logic [4:0] S_DWE  = 5'b00100;
  localparam logic [4:0] S_RWE  = 5'b00010;
  localparam logic [4:0] S_ILL  = 5'b00001;

  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_LW   = 32'h0000_A083;
  localparam logic [31:0] I_SW   = 32'h0011_2023;
  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_BAD  = 32'h0000_007F;

  logic        clk;
  logic        rst;
  logic [31:0] o_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_inst;
  logic [31:0] i_pc_next;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic        i_dmem_ack;
  logic        o_rd_we;
  logic        o_illegal;
  logic [2:0]  o_state;

  int n_chk;
  int n_pass;
  int n_fail;

  logic [31:0] exp_pc;
  logic [31:0] exp_inst;

  multicycle_ctrl #(.RESET_PC(RST_PC)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .o_pc         (o_pc),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_rdata (i_imem_rdata),
    .o_inst       (o_inst),
    .i_pc_next    (i_pc_next),
    .o_dmem_req   (o_dmem_req),
    .o_dmem_we    (o_dmem_we),
    .i_dmem_ack   (i_dmem_ack),
    .o_rd_we      (o_rd_we),
    .o_illegal    (o_illegal),
    .o_state      (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Check one cycle's outputs at the negedge, then drive inputs for the coming rising edge
  task automatic cycle(input string nm, input int st, input logic [4:0] strb,
                       input bit ia, input bit da, input logic [31:0] rdata);
    chk({nm, ".state"}, 32'(o_state), 32'(st));
    chk({nm, ".pc"}, o_pc, exp_pc);
    chk({nm, ".imem_addr"}, o_imem_addr, exp_pc);
    chk({nm, ".inst"}, o_inst, exp_inst);
    chk({nm, ".strobes"}, 32'({o_imem_req, o_dmem_req, o_dmem_we, o_rd_we, o_illegal}), 32'(strb));
    i_imem_ack   = ia;
    i_dmem_ack   = da;
    i_imem_rdata = rdata;
    @(negedge clk);
  endtask

  // Instruction-level model: the expected cycle timeline follows from the instruction's class
  // and the memory wait counts; acks outside their own request phase are random noise.
  task automatic run_instr(input string nm, input logic [31:0] inst, input int iw, input int dw,
                           input logic [31:0] pcn);
    logic [4:0] opc;
    bit lg, mem, sto, br;
    opc = inst[6:2];
    lg  = (inst[1:0] == 2'b11) &&
          (opc inside {5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                       5'b11011, 5'b11001, 5'b01101, 5'b00101});
    mem = lg && ((opc == 5'b00000) || (opc == 5'b01000));
    sto = lg && (opc == 5'b01000);
    br  = lg && (opc == 5'b11000);
    i_pc_next = pcn;
    for (int k = 0; k <= iw; k++) begin
      cycle({nm, ".fetch"}, 1, S_IREQ, (k == iw), rbit(), (k == iw) ? inst : $urandom);
    end
    exp_inst = inst;
    cycle({nm, ".decode"}, 2, lg ? S_NONE : S_ILL, rbit(), rbit(), $urandom);
    if (!lg) begin
      exp_pc = exp_pc + 32'd4;
      return;
    end
    cycle({nm, ".exec"}, 3, S_NONE, rbit(), rbit(), $urandom);
    if (br) begin
      exp_pc = pcn;
      return;
    end
    if (mem) begin
      for (int k = 0; k <= dw; k++) begin
        cycle({nm, ".mem"}, 4, sto ? (S_DREQ | S_DWE) : S_DREQ, rbit(), (k == dw), $urandom);
      end
      if (sto) begin
        exp_pc = pcn;
        return;
      end
    end
    cycle({nm, ".wb"}, 5, S_RWE, rbit(), rbit(), $urandom);
    exp_pc = pcn;
  endtask

  initial begin
    logic [4:0]  legal_opc [9];
    logic [31:0] w;
    n_chk = 0;
    n_pass = 0;
    n_fail = 0;
    legal_opc = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                  5'b11011, 5'b11001, 5'b01101, 5'b00101};
    rst = 1'b0;
    i_imem_ack = 1'b0;
    i_dmem_ack = 1'b0;
    i_imem_rdata = '0;
    i_pc_next = '0;
    #1 rst = 1'b1;
    exp_pc = RST_PC;
    exp_inst = '0;

    // Reset values, then one BOOT cycle before the first fetch
    @(negedge clk);
    cycle("reset", 0, S_NONE, 1'b1, 1'b1, 32'hDEAD_BEEF);
    rst = 1'b0;
    cycle("boot", 0, S_NONE, 1'b0, 1'b0, 32'h0);

    // Directed sequence
    run_instr("addi", I_ADDI, 0, 0, 32'h0000_0104);
    run_instr("lw_wait2", I_LW, 0, 2, 32'h0000_0108);
    run_instr("sw", I_SW, 1, 0, 32'h0000_010C);
    run_instr("beq", I_BEQ, 0, 0, 32'h0000_0080);
    run_instr("jal", I_JAL, 0, 0, 32'hFFFF_FFFC);
    run_instr("illegal_wrap", I_BAD, 0, 0, 32'h1234_5678);
    chk("wrap.pc_zero", o_pc, 32'h0);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      w = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        w[6:0] = {legal_opc[$urandom_range(0, 8)], 2'b11};
      end
      run_instr("rand", w, $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end

    // Reset asserted while a load waits in MEM
    i_pc_next = 32'h0000_0200;
    cycle("rstmem.fetch", 1, S_IREQ, 1'b1, 1'b0, I_LW);
    exp_inst = I_LW;
    cycle("rstmem.decode", 2, S_NONE, 1'b0, 1'b0, 32'h0);
    cycle("rstmem.exec", 3, S_NONE, 1'b0, 1'b0, 32'h0);
    chk("rstmem.dreq_before", 32'(o_dmem_req), 32'h1);
    #2 rst = 1'b1;
    i_dmem_ack = 1'b1;
    #1;
    chk("rstmem.dreq_drop", 32'(o_dmem_req), 32'h0);
    chk("rstmem.state", 32'(o_state), 32'h0);
    chk("rstmem.pc", o_pc, RST_PC);
    chk("rstmem.rd_we", 32'(o_rd_we), 32'h0);
    exp_pc = RST_PC;
    exp_inst = '0;
    @(negedge clk);
    cycle("rstmem.held", 0, S_NONE, 1'b0, 1'b1, 32'h0);
    rst = 1'b0;
    cycle("rstmem.boot", 0, S_NONE, 1'b0, 1'b1, 32'h0);
    run_instr("post_rst", I_ADDI, 0, 0, 32'h0000_0104);
    cycle("final", 1, S_IREQ, 1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
